dice_light_ctrl: RTL



---
 rtl/dice_light_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/dice_light_ctrl.sv
// ---------------------------------------------------------------------------
// dice_light_ctrl
//
// Sequencer for the shared 3-bit dice / traffic-light display. The lights are
// shown by default; a button press rolls the dice for at least MIN_ROLL
// cycles, the captured face is then shown for HOLD_CYCLES cycles, after
// which the display returns to the lights. force_lights reclaims the display
// from any state.
//
// Optional feature macro: DICE_LIGHT_CTRL_THROW_CHECK_EN
//   defined   : a captured face of 0 or 7 is discarded and a forced re-roll
//               of MIN_ROLL cycles is started.
//   undefined : throw_in is captured unconditionally.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   btn_in       user roll button (synchronised level)
//   force_lights priority request to show the traffic lights
//   throw_in     current dice value from the dice block
//   sel          display select (0 = dice, 1 = traffic lights)
//   dice_button  roll enable to the dice block
//   busy         high while rolling or showing a result
//   last_throw   most recently captured dice result
//   throw_valid  one-cycle pulse when last_throw updates
// ---------------------------------------------------------------------------
module dice_light_ctrl #(
    parameter int MIN_ROLL    = 3,
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    input  logic       force_lights,
    input  logic [2:0] throw_in,
    output logic       sel,
    output logic       dice_button,
    output logic       busy,
    output logic [2:0] last_throw,
    output logic       throw_valid
);

    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_ROLL);
    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    typedef enum logic [1:0] {
        LIGHTS = 2'd0,
        ROLL   = 2'd1,
        SHOW   = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             btn_q;
    logic             armed;
    logic             btn_rise;
    logic             cap_en;
    logic             face_ok;
    logic             sel_nx, dice_nx, busy_nx;

    // btn_q resets to 0, so on its own a button held through reset would look
    // like a fresh edge. 'armed' only opens the edge detector once the button
    // has been seen released after reset.
    assign btn_rise = btn_in & ~btn_q & armed;

`ifdef DICE_LIGHT_CTRL_THROW_CHECK_EN
    assign face_ok = (throw_in != 3'd0) && (throw_in != 3'd7);
`else
    assign face_ok = 1'b1;
`endif

    // -----------------------------------------------------------------------
    // State / counter / output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LIGHTS;
            cnt         <= '0;
            btn_q       <= 1'b0;
            armed       <= 1'b0;
            sel         <= 1'b1;
            dice_button <= 1'b0;
            busy        <= 1'b0;
            last_throw  <= 3'd0;
            throw_valid <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            btn_q       <= btn_in;
            armed       <= armed | ~btn_in;
            sel         <= sel_nx;
            dice_button <= dice_nx;
            busy        <= busy_nx;
            throw_valid <= cap_en;
            if (cap_en)
                last_throw <= throw_in;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state / counter logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cap_en   = 1'b0;
        if (force_lights) begin
            // Priority reclaim; a same-cycle button edge is dropped.
            state_nx = LIGHTS;
            cnt_nx   = '0;
        end else begin
            case (state)
                LIGHTS: begin
                    cnt_nx = '0;
                    if (btn_rise)
                        state_nx = ROLL;
                end
                ROLL: begin
                    if ((cnt >= MIN_C - ONE_C) && !btn_in) begin
                        state_nx = SHOW;
                        cnt_nx   = '0;
                    end else if (cnt < MIN_C) begin
                        cnt_nx = cnt + ONE_C;
                    end
                end
                SHOW: begin
                    if (btn_rise) begin
                        state_nx = ROLL;
                        cnt_nx   = '0;
                    end else if ((cnt == ONE_C) && !face_ok) begin
                        // Illegal face: discard it and roll again.
                        state_nx = ROLL;
                        cnt_nx   = '0;
                    end else begin
                        // Capture at count 1: the dice have been frozen for a
                        // full cycle, so throw_in is settled.
                        cap_en = (cnt == ONE_C);
                        if (cnt == HOLD_C - ONE_C) begin
                            state_nx = LIGHTS;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt + ONE_C;
                        end
                    end
                end
                default: begin
                    state_nx = LIGHTS;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Moore outputs, decoded from the next state so the registered outputs
    // line up with the state register.
    // -----------------------------------------------------------------------
    always_comb begin
        sel_nx  = 1'b1;
        dice_nx = 1'b0;
        busy_nx = 1'b0;
        case (state_nx)
            ROLL: begin
                sel_nx  = 1'b0;
                dice_nx = 1'b1;
                busy_nx = 1'b1;
            end
            SHOW: begin
                sel_nx  = 1'b0;
                busy_nx = 1'b1;
            end
            default: begin
                sel_nx  = 1'b1;
                dice_nx = 1'b0;
                busy_nx = 1'b0;
            end
        endcase
    end

endmodule
